// File: rtl/sadd_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and width limit.
package sadd_pkg;

    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder built from two half adders plus an OR of their carries.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum is a XOR b, carry is a AND b.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell walks the operands LSB first,
// with a carry flip-flop between bits and a start/busy/done handshake.
module serial_adder_ctrl
    import sadd_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_shift;
    logic             last_bit;

    fa_cell u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign res_shift = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (last_bit) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:  busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr_q  <= a_in;
                        b_sr_q  <= b_in;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    carry_q <= fa_c;
                    res_q   <= res_shift;
                    cnt_q   <= cnt_q + CW'(1);
                    // Outputs only ever see the complete result.
                    if (last_bit) begin
                        sum_q  <= res_shift;
                        cout_q <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances against a
// transaction-level model, plus directed cases with hand-computed results.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       start1 = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       busy1, done1, cout1, sum1;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a),
        .b_in  (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a_in  (a1),
        .b_in  (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: an accepted request keeps the block busy for W+1 cycles; the sum of the
    // captured operands appears when one cycle remains (the done cycle).
    int         m_left = 0;
    logic [8:0] m_pend = '0;
    logic [8:0] m_res = '0;
    int         m1_left = 0;
    logic [1:0] m1_pend = '0;
    logic [1:0] m1_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_res  <= '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= W + 1;
                m_pend <= {1'b0, a} + {1'b0, b};
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_res <= m_pend;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_left <= 0;
            m1_res  <= '0;
        end else if (m1_left == 0) begin
            if (start1) begin
                m1_left <= 2;
                m1_pend <= {1'b0, a1} + {1'b0, b1};
            end
        end else begin
            m1_left <= m1_left - 1;
            if (m1_left == 2) m1_res <= m1_pend;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("w8_busy", 32'(busy), 32'(m_left != 0));
            check("w8_done", 32'(done), 32'(m_left == 1));
            check("w8_sum", 32'(sum), 32'(m_res[7:0]));
            check("w8_cout", 32'(cout), 32'(m_res[8]));
            check("w1_busy", 32'(busy1), 32'(m1_left != 0));
            check("w1_done", 32'(done1), 32'(m1_left == 1));
            check("w1_sum", 32'(sum1), 32'(m1_res[0]));
            check("w1_cout", 32'(cout1), 32'(m1_res[1]));
        end
    end

    // One request with start pulsed for a single cycle; watches 14 cycles after accept.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, output int lat,
                          output int busyc, output int ndone, output logic [7:0] s,
                          output logic c);
        lat = -1;
        busyc = 0;
        ndone = 0;
        s = 'x;
        c = 1'bx;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        for (int k = 1; k <= 14; k++) begin
            if (busy) busyc++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
                s = sum;
                c = cout;
            end
            @(negedge clk);
        end
    endtask

    int         lat, busyc, ndone, nd;
    logic [7:0] s;
    logic       c;
    int         dk [2];
    logic [7:0] ds [2];
    logic       dc [2];
    logic [1:0] exp6 [4];

    initial begin
        exp6 = '{2'd0, 2'd1, 2'd1, 2'd2};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_w1_busy", 32'(busy1), 32'd0);

        // Basic add and latency
        run_op(8'h0F, 8'h01, lat, busyc, ndone, s, c);
        check("basic_latency", 32'(lat), 32'd9);
        check("basic_busy_cycles", 32'(busyc), 32'd9);
        check("basic_done_count", 32'(ndone), 32'd1);
        check("basic_sum", 32'(s), 32'h10);
        check("basic_cout", 32'(c), 32'd0);

        // Overflow
        run_op(8'hFF, 8'h01, lat, busyc, ndone, s, c);
        check("ovf1_sum", 32'(s), 32'h00);
        check("ovf1_cout", 32'(c), 32'd1);
        run_op(8'hFF, 8'hFF, lat, busyc, ndone, s, c);
        check("ovf2_sum", 32'(s), 32'hFE);
        check("ovf2_cout", 32'(c), 32'd1);

        // Reset mid-RUN after three bits
        @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run_op(8'h12, 8'h34, lat, busyc, ndone, s, c);
        check("after_rst_sum", 32'(s), 32'h46);
        check("after_rst_latency", 32'(lat), 32'd9);

        // Busy protection: start held, operands churn during RUN
        @(negedge clk);
        a = 8'h21;
        b = 8'h43;
        start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                s = sum;
                c = cout;
            end
            if (k >= 9) begin
                start = 1'b0;
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
        end
        check("protect_done_count", 32'(ndone), 32'd1);
        check("protect_sum", 32'(s), 32'h64);
        check("protect_cout", 32'(c), 32'd0);

        // Back-to-back with start held continuously
        @(negedge clk);
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        nd = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                if (nd < 2) begin
                    dk[nd] = k;
                    ds[nd] = sum;
                    dc[nd] = cout;
                end
                nd++;
                if (nd == 1) begin
                    a = 8'd200;
                    b = 8'd100;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(nd), 32'd2);
        if (nd == 2) begin
            check("b2b_first_latency", 32'(dk[0]), 32'd9);
            check("b2b_spacing", 32'(dk[1] - dk[0]), 32'd10);
            check("b2b_sum0", 32'(ds[0]), 32'h08);
            check("b2b_cout0", 32'(dc[0]), 32'd0);
            check("b2b_sum1", 32'(ds[1]), 32'h2C);
            check("b2b_cout1", 32'(dc[1]), 32'd1);
        end

        // WIDTH=1 instance, all operand combinations
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a1 = i[1];
            b1 = i[0];
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            lat = -1;
            s = '0;
            for (int k = 1; k <= 4; k++) begin
                if (done1 && lat < 0) begin
                    lat = k;
                    s = {6'd0, cout1, sum1};
                end
                @(negedge clk);
            end
            check("w1_latency", 32'(lat), 32'd2);
            check("w1_result", 32'(s), 32'(exp6[i]));
        end

        // Random traffic against the model, with one asynchronous reset pulse
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a = 8'($urandom);
            b = 8'($urandom);
            start1 = ($urandom_range(0, 1) == 0);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            if (n == 200) begin
                #2 rst = 1'b1;
                #3 rst = 1'b0;
            end
        end
        start = 1'b0;
        start1 = 1'b0;
        repeat (15) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
